// File: rtl/certuspro_nx_evn_pkg.sv
// Board-level constants and shared types for the CertusPro-NX evaluation board.
package certuspro_nx_evn_pkg;

  localparam int unsigned LED_COUNT = 8;
  localparam real CLK_12MHZ_FREQUENCY = 12.0e6;

  typedef logic [7:0] led_level_t;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } led_fader_state_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: linear level ramp toward an on/off target plus PWM compare
// driving a registered active-low pin.
module led_pwm_channel
  import certuspro_nx_evn_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                tgt_on,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_n,
  output logic                at_target_c
);

  localparam logic [PWM_BITS-1:0] FULL = '1;

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic                led_n_q, led_n_d;
  logic                lit;

  // Reports the post-step compare so the FSM can leave FADE on the final tick.
  always_comb begin
    target_d = target_q;
    level_d  = level_q;
    if (load) begin
      target_d = tgt_on ? FULL : '0;
    end
    if (tick) begin
      if (level_q < target_q) begin
        level_d = level_q + PWM_BITS'(1);
      end else if (level_q > target_q) begin
        level_d = level_q - PWM_BITS'(1);
      end
    end
    at_target_c = (level_d == target_q);
    lit         = (pwm_cnt < level_q) || (level_q == FULL);
    led_n_d     = ~lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      target_q <= '0;
      led_n_q  <= 1'b1;
    end else begin
      level_q  <= level_d;
      target_q <= target_d;
      led_n_q  <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule

// File: rtl/led_fader.sv
// LED output stage: accepts an on/off pattern, fades each channel linearly
// toward it and drives active-low PWM pins.
module led_fader
  import certuspro_nx_evn_pkg::*;
#(
  parameter int unsigned FADE_DIV = 11765,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  input  logic [LED_COUNT-1:0] pattern,
  input  logic                 pattern_valid,
  output logic                 pattern_ready,
  output logic                 busy,
  output logic [LED_COUNT-1:0] led
);

  localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  led_fader_state_t    state_q, state_d;
  logic                ready_q, busy_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                load, tick, all_at_target;
  logic [LED_COUNT-1:0] at_target_c;

  assign all_at_target = &at_target_c;

  // Divider only runs while fading and restarts from zero on every transfer.
  always_comb begin
    load      = (state_q == IDLE) && pattern_valid;
    tick      = (state_q == FADE) && (div_q == DIV_W'(FADE_DIV - 1));
    div_d     = '0;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    state_d   = state_q;
    if (state_q == FADE && !tick) begin
      div_d = div_q + DIV_W'(1);
    end
    if (state_q == IDLE) begin
      if (pattern_valid) begin
        state_d = FADE;
      end
    end else if (tick && all_at_target) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      div_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d == FADE);
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pattern_ready = ready_q;
  assign busy          = busy_q;

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk        (clk_12mhz),
      .rst        (rst),
      .load       (load),
      .tgt_on     (pattern[i]),
      .tick       (tick),
      .pwm_cnt    (pwm_cnt_q),
      .led_n      (led[i]),
      .at_target_c(at_target_c[i])
    );
  end

endmodule
